// File: rtl/param_password_lock.sv
// Parametrised password lock: edge-qualified entry, timed lockout after repeated failures,
// auto-relock from UNLOCKED, and password change allowed only while unlocked.
module param_password_lock #(
  parameter int unsigned      PWD_W          = 16,
  parameter logic [PWD_W-1:0] DEFAULT_PWD    = PWD_W'(1234),
  parameter int unsigned      MAX_ATTEMPTS   = 3,
  parameter int unsigned      LOCKOUT_CYCLES = 64,
  parameter int unsigned      RELOCK_CYCLES  = 32
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [PWD_W-1:0]                    password_input,
  input  logic                                enter,
  input  logic                                reset_pwd,
  input  logic                                relock,
  output logic                                locked,
  output logic                                lockout,
  output logic [$clog2(MAX_ATTEMPTS+1)-1:0]   attempts_left,
  output logic                                fail,
  output logic                                pwd_changed
);

  localparam int unsigned AW   = $clog2(MAX_ATTEMPTS + 1);
  localparam int unsigned TMAX = (LOCKOUT_CYCLES > RELOCK_CYCLES) ? LOCKOUT_CYCLES : RELOCK_CYCLES;
  localparam int unsigned TW   = $clog2(TMAX + 1);

  typedef enum logic [1:0] {
    S_LOCKED   = 2'd0,
    S_UNLOCKED = 2'd1,
    S_LOCKOUT  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [PWD_W-1:0] pwd_q, pwd_d;
  logic [TW-1:0]    timer_q, timer_d;
  logic [AW-1:0]    att_q, att_d;
  logic             enter_prev_q, rp_prev_q;
  logic             locked_q, locked_d;
  logic             lockout_q, lockout_d;
  logic             fail_q, fail_d;
  logic             chg_q, chg_d;

  logic enter_evt, rp_evt, match;

  assign enter_evt = enter & ~enter_prev_q;
  assign rp_evt    = reset_pwd & ~rp_prev_q;
  assign match     = (password_input == pwd_q);

  // Next-state and next-output logic; the shared timer serves both lockout and relock.
  always_comb begin
    state_d = state_q;
    pwd_d   = pwd_q;
    timer_d = timer_q;
    att_d   = att_q;
    fail_d  = 1'b0;
    chg_d   = 1'b0;

    case (state_q)
      S_LOCKED: begin
        if (enter_evt) begin
          if (match) begin
            state_d = S_UNLOCKED;
            att_d   = AW'(MAX_ATTEMPTS);
            timer_d = TW'(RELOCK_CYCLES);
          end else begin
            fail_d = 1'b1;
            if (att_q <= AW'(1)) begin
              state_d = S_LOCKOUT;
              att_d   = '0;
              timer_d = TW'(LOCKOUT_CYCLES);
            end else begin
              att_d = att_q - AW'(1);
            end
          end
        end
      end

      S_LOCKOUT: begin
        if (timer_q <= TW'(1)) begin
          state_d = S_LOCKED;
          att_d   = AW'(MAX_ATTEMPTS);
          timer_d = '0;
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end

      S_UNLOCKED: begin
        if (rp_evt) begin
          pwd_d   = password_input;
          chg_d   = 1'b1;
          state_d = S_LOCKED;
          timer_d = '0;
        end else if (relock) begin
          state_d = S_LOCKED;
          timer_d = '0;
        end else if (enter_evt && match) begin
          timer_d = TW'(RELOCK_CYCLES);
        end else if (RELOCK_CYCLES != 0) begin
          if (timer_q <= TW'(1)) begin
            state_d = S_LOCKED;
            timer_d = '0;
          end else begin
            timer_d = timer_q - TW'(1);
          end
        end
      end

      default: begin
        state_d = S_LOCKED;
        timer_d = '0;
        att_d   = AW'(MAX_ATTEMPTS);
      end
    endcase

    locked_d  = (state_d != S_UNLOCKED);
    lockout_d = (state_d == S_LOCKOUT);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_LOCKED;
      pwd_q        <= DEFAULT_PWD;
      timer_q      <= '0;
      att_q        <= AW'(MAX_ATTEMPTS);
      enter_prev_q <= 1'b0;
      rp_prev_q    <= 1'b0;
      locked_q     <= 1'b1;
      lockout_q    <= 1'b0;
      fail_q       <= 1'b0;
      chg_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      pwd_q        <= pwd_d;
      timer_q      <= timer_d;
      att_q        <= att_d;
      enter_prev_q <= enter;
      rp_prev_q    <= reset_pwd;
      locked_q     <= locked_d;
      lockout_q    <= lockout_d;
      fail_q       <= fail_d;
      chg_q        <= chg_d;
    end
  end

  assign locked        = locked_q;
  assign lockout       = lockout_q;
  assign attempts_left = att_q;
  assign fail          = fail_q;
  assign pwd_changed   = chg_q;

endmodule

// File: tb/tb_param_password_lock.sv
// Table-driven bench for param_password_lock: one vector per clock, expected outputs
// queued when a vector is driven and compared after the sampling edge.
module tb_param_password_lock;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] password_input = '0;
  logic        enter = 1'b0, reset_pwd = 1'b0, relock = 1'b0;
  logic        locked, lockout, fail, pwd_changed;
  logic [1:0]  attempts_left;

  typedef struct {
    logic        rst, en, rp, rl;
    logic [15:0] pwd;
    logic        el, elo;
    logic [1:0]  ea;
    logic        ef, ec;
  } vec_t;

  vec_t tbl[$];
  vec_t sb[$];
  int   n_vec = 0;
  int   n_bad = 0;

  param_password_lock #(
    .PWD_W(16), .DEFAULT_PWD(16'd1234), .MAX_ATTEMPTS(3),
    .LOCKOUT_CYCLES(8), .RELOCK_CYCLES(6)
  ) dut (
    .clk(clk), .rst(rst), .password_input(password_input),
    .enter(enter), .reset_pwd(reset_pwd), .relock(relock),
    .locked(locked), .lockout(lockout), .attempts_left(attempts_left),
    .fail(fail), .pwd_changed(pwd_changed)
  );

  always #5 clk = ~clk;

  task automatic add(input logic r, input logic en, input logic rp, input logic rl,
                     input logic [15:0] pwd, input logic el, input logic elo,
                     input logic [1:0] ea, input logic ef, input logic ec);
    vec_t v;
    v.rst = r; v.en = en; v.rp = rp; v.rl = rl; v.pwd = pwd;
    v.el = el; v.elo = elo; v.ea = ea; v.ef = ef; v.ec = ec;
    tbl.push_back(v);
  endtask

  task automatic idle(input logic el, input logic elo, input logic [1:0] ea);
    add(0, 0, 0, 0, 16'd0, el, elo, ea, 0, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t e;
    // 1: two wrong entries then the default password unlocks; explicit relock
    add(1, 0, 0, 0, 16'd0,    1, 0, 3, 0, 0);
    add(0, 1, 0, 0, 16'd1111, 1, 0, 2, 1, 0);
    idle(1, 0, 2);
    add(0, 1, 0, 0, 16'd2222, 1, 0, 1, 1, 0);
    idle(1, 0, 1);
    add(0, 1, 0, 0, 16'd1234, 0, 0, 3, 0, 0);
    idle(0, 0, 3);
    add(0, 0, 0, 1, 16'd0,    1, 0, 3, 0, 0);
    // 2: three wrong entries -> 8-cycle lockout, entries ignored meanwhile
    add(0, 1, 0, 0, 16'd1111, 1, 0, 2, 1, 0);
    idle(1, 0, 2);
    add(0, 1, 0, 0, 16'd2222, 1, 0, 1, 1, 0);
    idle(1, 0, 1);
    add(0, 1, 0, 0, 16'd3333, 1, 1, 0, 1, 0);
    idle(1, 1, 0);
    add(0, 1, 0, 0, 16'd1234, 1, 1, 0, 0, 0);
    for (int i = 0; i < 5; i++) idle(1, 1, 0);
    idle(1, 0, 3);
    add(0, 1, 0, 0, 16'd1234, 0, 0, 3, 0, 0);
    // 3: change password while unlocked; old one now fails, new one works
    idle(0, 0, 3);
    add(0, 0, 1, 0, 16'd5678, 1, 0, 3, 0, 1);
    idle(1, 0, 3);
    add(0, 1, 0, 0, 16'd1234, 1, 0, 2, 1, 0);
    idle(1, 0, 2);
    add(0, 1, 0, 0, 16'd5678, 0, 0, 3, 0, 0);
    // 4: auto-relock 6 cycles after unlock, then reload by a matching enter
    for (int i = 0; i < 5; i++) idle(0, 0, 3);
    idle(1, 0, 3);
    add(0, 1, 0, 0, 16'd5678, 0, 0, 3, 0, 0);
    for (int i = 0; i < 3; i++) idle(0, 0, 3);
    add(0, 1, 0, 0, 16'd5678, 0, 0, 3, 0, 0);
    idle(0, 0, 3);
    add(0, 1, 0, 0, 16'd0,    0, 0, 3, 0, 0);
    for (int i = 0; i < 3; i++) idle(0, 0, 3);
    idle(1, 0, 3);
    // 5: held enter yields one event; reset_pwd wins over relock
    add(0, 1, 0, 0, 16'd1111, 1, 0, 2, 1, 0);
    for (int i = 0; i < 4; i++) add(0, 1, 0, 0, 16'd1111, 1, 0, 2, 0, 0);
    idle(1, 0, 2);
    add(0, 1, 0, 0, 16'd5678, 0, 0, 3, 0, 0);
    add(0, 0, 1, 1, 16'd4321, 1, 0, 3, 0, 1);
    idle(1, 0, 3);
    add(0, 1, 0, 0, 16'd5678, 1, 0, 2, 1, 0);
    idle(1, 0, 2);
    add(0, 1, 0, 0, 16'd4321, 0, 0, 3, 0, 0);
    // 6: reset mid-lockout restores defaults and the default password
    add(0, 0, 0, 1, 16'd0,    1, 0, 3, 0, 0);
    add(0, 1, 0, 0, 16'd1111, 1, 0, 2, 1, 0);
    idle(1, 0, 2);
    add(0, 1, 0, 0, 16'd2222, 1, 0, 1, 1, 0);
    idle(1, 0, 1);
    add(0, 1, 0, 0, 16'd3333, 1, 1, 0, 1, 0);
    for (int i = 0; i < 5; i++) idle(1, 1, 0);
    add(1, 0, 0, 0, 16'd0,    1, 0, 3, 0, 0);
    add(0, 0, 1, 0, 16'd9999, 1, 0, 3, 0, 0);
    idle(1, 0, 3);
    add(0, 1, 0, 0, 16'd4321, 1, 0, 2, 1, 0);
    idle(1, 0, 2);
    add(0, 1, 0, 0, 16'd1234, 0, 0, 3, 0, 0);

    foreach (tbl[i]) begin
      @(negedge clk);
      rst            = tbl[i].rst;
      enter          = tbl[i].en;
      reset_pwd      = tbl[i].rp;
      relock         = tbl[i].rl;
      password_input = tbl[i].pwd;
      sb.push_back(tbl[i]);
      @(posedge clk);
      #1;
      e = sb.pop_front();
      n_vec++;
      if (locked !== e.el || lockout !== e.elo || attempts_left !== e.ea ||
          fail !== e.ef || pwd_changed !== e.ec) begin
        n_bad++;
        $display("FAIL vec%0d: got locked=%b lockout=%b att=%0d fail=%b chg=%b, want locked=%b lockout=%b att=%0d fail=%b chg=%b",
                 i, locked, lockout, attempts_left, fail, pwd_changed,
                 e.el, e.elo, e.ea, e.ef, e.ec);
      end
    end

    if (n_vec != tbl.size()) begin
      n_bad++;
      $display("FAIL count: got %0d vectors applied, want %0d", n_vec, tbl.size());
    end
    if (locked !== 1'b0) begin
      n_bad++;
      $display("FAIL final: got locked=%b, want 0", locked);
    end
    if (lockout !== 1'b0) begin
      n_bad++;
      $display("FAIL final: got lockout=%b, want 0", lockout);
    end
    if (attempts_left !== 2'd3) begin
      n_bad++;
      $display("FAIL final: got attempts_left=%0d, want 3", attempts_left);
    end
    if (fail !== 1'b0 || pwd_changed !== 1'b0) begin
      n_bad++;
      $display("FAIL final: got fail=%b chg=%b, want 0 0", fail, pwd_changed);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    if (n_bad == 0) $display("PASS");
    else            $display("FAIL: %0d miscompares", n_bad);
    $finish;
  end

endmodule
